// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, entry type and SECDED bit-placement helper for the
// DDR2 write-data buffer.
package wb_pkg;

  localparam int WB_DATA_W  = 128;
  localparam int WB_HALF_W  = 64;
  localparam int WB_ECC_W   = 8;
  localparam int WB_ENTRY_W = WB_DATA_W + 2 * WB_ECC_W;

  // [127:0] data, [135:128] check of [63:0], [143:136] check of [127:64]
  typedef logic [WB_ENTRY_W-1:0] wb_entry_t;

  // Codeword position (1..71) of data bit d: data bits fill the positions
  // that are not powers of two, in ascending order.
  function automatic logic [6:0] wb_ham_pos(input int unsigned d);
    logic [6:0]  pos;
    int unsigned k;
    pos = 7'd0;
    k   = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == d) begin
          pos = 7'(p);
        end
        k++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc72_enc.sv
// ecc72_enc: combinational (72,64) Hamming SECDED encoder.
// ecc_o[6:0] are the Hamming bits (bit i covers positions with bit i set),
// ecc_o[7] is the overall parity over data and Hamming bits.
module ecc72_enc
  import wb_pkg::*;
(
  input  logic [WB_HALF_W-1:0] data_i,
  output logic [WB_ECC_W-1:0]  ecc_o
);

  logic [6:0] ham_s;

  // Fold every data bit into the Hamming bits selected by its position
  always_comb begin
    logic [6:0] pos;
    ham_s = 7'd0;
    for (int d = 0; d < WB_HALF_W; d++) begin
      pos = wb_ham_pos(unsigned'(d));
      for (int b = 0; b < 7; b++) begin
        ham_s[b] = ham_s[b] ^ (data_i[d] & pos[b]);
      end
    end
  end

  assign ecc_o = {(^data_i) ^ (^ham_s), ham_s};

endmodule

// File: rtl/wb_ecc_fifo.sv
// wb_ecc_fifo: 128-bit write-data FIFO with per-half SECDED check bytes,
// first-word-fall-through head register.
// Pipeline: encode register E -> storage array S -> head register (MD).
// Head refills from S, or straight from E when S holds nothing.
// Optional macro WB_ECC_EN: when undefined, MD[143:128] is forced to zero
// and the encoders are removed; stage E stays so timing is unchanged.
module wb_ecc_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int AF_OFFSET = 384,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [WB_DATA_W-1:0] WD,
  input  logic                 WDen,
  output logic                 Full,
  output wb_entry_t            MD,
  input  logic                 MDen,
  output logic                 Empty,
  output logic [CW-1:0]        Count,
  output logic                 Overflow,
  output logic                 Underflow
);

  wb_entry_t             mem_q [DEPTH];
  wb_entry_t             e_q, hd_q, enc_s;
  logic                  e_vld_q, hd_vld_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, ovf_q, unf_q;
  logic                  push_s, pop_s, hd_load_s, s_empty_s;
  logic                  hd_from_s_s, hd_from_e_s, s_wr_s;
  logic [WB_ECC_W-1:0]   ecc_lo_s, ecc_hi_s;

`ifdef WB_ECC_EN
  ecc72_enc u_enc_lo (.data_i(WD[WB_HALF_W-1:0]),         .ecc_o(ecc_lo_s));
  ecc72_enc u_enc_hi (.data_i(WD[WB_DATA_W-1:WB_HALF_W]), .ecc_o(ecc_hi_s));
`else
  assign ecc_lo_s = 8'h00;
  assign ecc_hi_s = 8'h00;
`endif

  assign enc_s = {ecc_hi_s, ecc_lo_s, WD};

  // Accept/route decisions and next-state for pointers and occupancy.
  // S never holds DEPTH entries while E or head is occupied, so pointer
  // equality alone means S is empty.
  always_comb begin
    pop_s       = MDen && hd_vld_q;
    push_s      = WDen && ((count_q < CW'(DEPTH)) || pop_s);
    hd_load_s   = !hd_vld_q || pop_s;
    s_empty_s   = (wr_ptr_q == rd_ptr_q);
    hd_from_s_s = hd_load_s && !s_empty_s;
    hd_from_e_s = hd_load_s && s_empty_s && e_vld_q;
    s_wr_s      = e_vld_q && !hd_from_e_s;
    wr_ptr_d    = s_wr_s      ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = hd_from_s_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control, encode stage, head register and sticky flags
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      e_q      <= '0;
      e_vld_q  <= 1'b0;
      hd_q     <= '0;
      hd_vld_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      e_vld_q  <= push_s;
      if (push_s) begin
        e_q <= enc_s;
      end
      if (hd_from_s_s) begin
        hd_q <= mem_q[rd_ptr_q];
      end else if (hd_from_e_s) begin
        hd_q <= e_q;
      end
      if (hd_load_s) begin
        hd_vld_q <= hd_from_s_s || hd_from_e_s;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d >= CW'(AF_OFFSET));
      if (WDen && !push_s) begin
        ovf_q <= 1'b1;
      end
      if (MDen && !hd_vld_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  // Storage array write port (no reset so it maps onto block RAM)
  always_ff @(posedge Clk) begin
    if (s_wr_s) begin
      mem_q[wr_ptr_q] <= e_q;
    end
  end

  assign MD        = hd_q;
  assign Empty     = !hd_vld_q;
  assign Count     = count_q;
  assign Full      = full_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_wb_ecc_fifo.sv
// tb_wb_ecc_fifo: directed, table-driven bench for wb_ecc_fifo.
module tb_wb_ecc_fifo;

  localparam int DEPTH = 512;
  localparam int AF    = 384;
`ifdef WB_ECC_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  logic         Clk, Reset_n, WDen, MDen;
  logic [127:0] WD;
  logic         Full, Empty, Overflow, Underflow;
  logic [143:0] MD;
  logic [9:0]   Count;

  int n_tests = 0;
  int n_fail  = 0;

  wb_ecc_fifo #(.DEPTH(DEPTH), .AF_OFFSET(AF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .WD(WD), .WDen(WDen), .Full(Full),
    .MD(MD), .MDen(MDen), .Empty(Empty), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [127:0] wd;
    logic [143:0] md;
  } vec_t;
  vec_t vecs [4];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference codeword position of data bit d (non-power-of-two slots)
  function automatic logic [6:0] tb_pos(input int d);
    int k;
    k = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == d) return 7'(p);
        k++;
      end
    end
    return 7'd0;
  endfunction

  // Reference decoder: {overall parity error, 7-bit syndrome}
  function automatic logic [7:0] dec(input logic [63:0] d, input logic [7:0] e);
    logic [6:0] syn;
    syn = e[6:0];
    for (int i = 0; i < 64; i++) begin
      if (d[i]) syn = syn ^ tb_pos(i);
    end
    return {(^d) ^ (^e), syn};
  endfunction

  initial begin
    logic [143:0] md_prev;
    logic [71:0]  w;
    logic [7:0]   exp_d;

    WD = 128'h0; WDen = 1'b0; MDen = 1'b0; Reset_n = 1'b0;
    vecs[0].wd = 128'h0;
    vecs[0].md = 144'h0;
    vecs[1].wd = {64'h1, 64'h8000_0000_0000_0000};
    vecs[1].md = {(ECC_ON ? 16'h83C7 : 16'h0000), 64'h1, 64'h8000_0000_0000_0000};
    vecs[2].wd = {64'h2, 64'h3};
    vecs[2].md = {(ECC_ON ? 16'h8506 : 16'h0000), 64'h2, 64'h3};
    vecs[3].wd = {128{1'b1}};
    vecs[3].md = {(ECC_ON ? 16'hFFFF : 16'h0000), {128{1'b1}}};

    tick(); tick();
    Reset_n = 1'b1;
    chk("rst_count", 144'(Count), 144'd0);
    chk("rst_empty", 144'(Empty), 144'd1);
    chk("rst_full",  144'(Full),  144'd0);
    chk("rst_md",    MD,          144'd0);
    chk("rst_ovf",   144'(Overflow),  144'd0);
    chk("rst_unf",   144'(Underflow), 144'd0);

    // Single push/pop per vector: latency and encoded contents
    for (int i = 0; i < 4; i++) begin
      WD = vecs[i].wd; WDen = 1'b1;
      tick();
      WDen = 1'b0;
      chk("lat1_empty", 144'(Empty), 144'd1);
      chk("lat1_count", 144'(Count), 144'd1);
      tick();
      chk("lat2_empty", 144'(Empty), 144'd0);
      chk("vec_md", MD, vecs[i].md);
      MDen = 1'b1;
      tick();
      MDen = 1'b0;
      chk("pop_empty", 144'(Empty), 144'd1);
      chk("pop_count", 144'(Count), 144'd0);
    end

`ifdef WB_ECC_EN
    // Decode both halves clean, then every single-bit flip
    WD = vecs[1].wd; WDen = 1'b1;
    tick(); WDen = 1'b0; tick();
    md_prev = MD;
    chk("syn_lo_clean", 144'(dec(md_prev[63:0],   md_prev[135:128])), 144'd0);
    chk("syn_hi_clean", 144'(dec(md_prev[127:64], md_prev[143:136])), 144'd0);
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 72; k++) begin
        w = (h == 0) ? {md_prev[135:128], md_prev[63:0]} : {md_prev[143:136], md_prev[127:64]};
        w[k] = ~w[k];
        if (k < 64)      exp_d = {1'b1, tb_pos(k)};
        else if (k < 71) exp_d = {1'b1, 7'(1 << (k - 64))};
        else             exp_d = 8'h80;
        chk("syn_flip", 144'(dec(w[63:0], w[71:64])), 144'(exp_d));
      end
    end
    MDen = 1'b1; tick(); MDen = 1'b0;
`endif

    // Pop while empty, then reset with 100 entries queued
    md_prev = MD;
    MDen = 1'b1; tick(); MDen = 1'b0;
    chk("unf_flag",  144'(Underflow), 144'd1);
    chk("unf_count", 144'(Count), 144'd0);
    chk("unf_md",    MD, md_prev);
    chk("unf_empty", 144'(Empty), 144'd1);
    WDen = 1'b1;
    for (int i = 0; i < 100; i++) begin
      WD = 128'(i); tick();
    end
    WDen = 1'b0;
    chk("q100_count", 144'(Count), 144'd100);
    Reset_n = 1'b0; tick(); Reset_n = 1'b1;
    chk("mrst_count", 144'(Count), 144'd0);
    chk("mrst_empty", 144'(Empty), 144'd1);
    chk("mrst_full",  144'(Full),  144'd0);
    chk("mrst_ovf",   144'(Overflow),  144'd0);
    chk("mrst_unf",   144'(Underflow), 144'd0);
    tick();
    chk("mrst_ghost", 144'(Empty), 144'd1);

    // Fill to almost-full, to full, overflow, then drain in order
    WDen = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      WD = {64'(i), 64'(i) ^ 64'hA5A5_A5A5_A5A5_A5A5};
      tick();
      if (i + 1 == AF - 1) begin
        chk("af_below", 144'(Full), 144'd0);
        chk("af_below_cnt", 144'(Count), 144'(AF - 1));
      end
      if (i + 1 == AF) begin
        chk("af_reach", 144'(Full), 144'd1);
        chk("af_reach_cnt", 144'(Count), 144'(AF));
      end
    end
    chk("full_count", 144'(Count), 144'(DEPTH));
    chk("full_noovf", 144'(Overflow), 144'd0);
    WD = 128'hDEAD;
    tick();
    WDen = 1'b0;
    chk("ovf_flag",  144'(Overflow), 144'd1);
    chk("ovf_count", 144'(Count), 144'(DEPTH));
    MDen = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      chk("drain_md", 144'(MD[127:0]), 144'({64'(j), 64'(j) ^ 64'hA5A5_A5A5_A5A5_A5A5}));
      chk("drain_empty", 144'(Empty), 144'd0);
      tick();
    end
    MDen = 1'b0;
    chk("drain_end_empty", 144'(Empty), 144'd1);
    chk("drain_end_count", 144'(Count), 144'd0);
    chk("drain_end_unf",   144'(Underflow), 144'd0);

    // Sustained push+pop across pointer wrap
    Reset_n = 1'b0; tick(); Reset_n = 1'b1;
    WDen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      WD = 128'(i); tick();
    end
    MDen = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      WD = 128'(c + 10);
      chk("stream_md",    144'(MD[127:0]), 144'(c));
      chk("stream_count", 144'(Count), 144'd10);
      tick();
    end
    WDen = 1'b0; MDen = 1'b0;
    chk("stream_ovf", 144'(Overflow),  144'd0);
    chk("stream_unf", 144'(Underflow), 144'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time bound on the whole run
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_ecc_fifo.md
# wb_ecc_fifo

Write-data buffer for the DDR2 SODIMM controller: carries 128-bit user write data toward the DRAM data path. It generates SECDED check bytes per 64-bit half, stores data plus check bytes in a single-clock FIFO, and presents them first-word-fall-through to the memory-side sequencer. It is the transmit-side counterpart of the controller's ECC-checking read buffer.

## Interface
- DEPTH, 512: FIFO entries; power of two, ≥ 4.
- AF_OFFSET, 384: Full asserts when Count ≥ AF_OFFSET; range 1..DEPTH-1.
- Clk  in  1  single clock for both sides.
- Reset_n  in  1  reset; one clock; synchronous, active-low.
- WD  in  128  user write data.
- WDen  in  1  push WD this cycle.
- Full  out  1  almost-full; user must stop pushing while high.
- MD  out  144  head entry: [127:0] data, [135:128] check byte of [63:0], [143:136] check byte of [127:64].
- MDen  in  1  memory side pops head this cycle.
- Empty  out  1  no valid head; MD undefined-but-stable when high.
- Count  out  $clog2(DEPTH)+1  occupancy, including encode stage.
- Overflow  out  1  sticky: push seen with Count == DEPTH.
- Underflow  out  1  sticky: pop seen with Empty high.

## Operation
- Stage E (encode): on an accepted push, WD is registered together with two 8-bit check bytes. These are Hamming SECDED (72,64) codes: 7 Hamming bits plus overall parity, bit layout of the Virtex-5 block-RAM ECC.
- Stage S (storage): a DEPTH-entry array of 144 bits, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Head register: holds the oldest entry; it refills from S or directly from E when S is empty (FWFT).
- Accepted push: WDen && Count < DEPTH. A push at Count == DEPTH is dropped, sets Overflow, and leaves state unchanged.
- Accepted pop: MDen && !Empty. A pop with Empty high is ignored and sets Underflow.
- Simultaneous accepted push and pop: Count unchanged, both pointers advance, no data loss. This includes Count == DEPTH with a pop: the push is accepted.
- Count: +1 on accepted push, −1 on accepted pop. It never exceeds DEPTH and never goes below 0.
- Overflow and Underflow clear only on reset.
- Reset mid-operation discards all contents, including stage E.

## Timing
- Reset values: Count 0, Empty 1, Full 0, MD 0, Overflow 0, Underflow 0, pointers 0.
- Push at cycle N:
  - Count increments at N+1.
  - If the FIFO was empty, Empty falls at N+2 with MD valid.
- Pop at cycle N: MD shows the next entry at N+1, or Empty rises at N+1 if none remain.
- Full is registered, updated with Count: high in the cycle where Count ≥ AF_OFFSET. The AF_OFFSET..DEPTH margin absorbs user response latency.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- WB_ECC_EN defined: check bytes are computed as above.
- WB_ECC_EN undefined: MD[143:128] is forced to 0, the encoder is removed, and stage E remains, so latency and flag timing are identical.

## Structure
- Shared package wb_pkg: WB_DATA_W = 128, WB_HALF_W = 64, WB_ECC_W = 8, and a typedef for the 144-bit entry.
- One sub-module, ecc72_enc: purely combinational 64→8 SECDED encoder, instantiated twice in stage E.
- The array infers block RAM with a registered read. The FIFO control stays in wb_ecc_fifo.

## Test plan
- Reset then push WD = 0 → MD = 144'h0, and Empty falls exactly 2 cycles after WDen.
- Push WD = {64'h1, 64'h8000_0000_0000_0000} → the bench's reference SECDED decoder reports zero syndrome on both halves. Flipping any single MD bit yields a single-error syndrome that locates that bit.
- Push 384 words with no pops → Full rises the cycle Count reaches 384. Push to 512, then one more push → Overflow = 1, Count stays 512, and the first 512 words drain in order.
- Push and pop every cycle for 2000 cycles with an incrementing pattern → Count constant, no gaps, order preserved across pointer wrap.
- Pop while Empty → Underflow = 1, Count stays 0, MD unchanged.
- Assert Reset_n low for one cycle with 100 entries queued → next cycle Count = 0, Empty = 1, Full = 0, and both flags are 0.
- Build without WB_ECC_EN and push WD = 128'hFFFF… → MD[143:128] = 0 with identical latency.
